// File: rtl/moving_sum_if.sv
// Sample/window bus between the stream source and the moving_sum accumulator.
interface moving_sum_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned LEN = 4
);
    localparam int unsigned SW = DW + $clog2(LEN);

    logic          en;
    logic          clr;
    logic [DW-1:0] din;
    logic [DW-1:0] din_dly;
    logic [SW-1:0] sum;
    logic [DW-1:0] avg;
    logic          valid;

    modport master (
        output en, clr, din, din_dly,
        input  sum, avg, valid
    );

    modport slave (
        input  en, clr, din, din_dly,
        output sum, avg, valid
    );
endinterface

// File: rtl/moving_sum.sv
// Windowed running sum and rounded mean over the last LEN accepted samples,
// fed by a matching-length delay chain that supplies the sample leaving the window.
module moving_sum #(
    parameter int unsigned DW  = 8,
    parameter int unsigned LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    moving_sum_if.slave  bus
);
    localparam int unsigned SW = DW + $clog2(LEN);
    localparam int unsigned LW = $clog2(LEN);
    localparam int unsigned FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);
    localparam logic [SW-1:0] HALF = SW'(LEN / 2);

    if ((LEN < 2) || ((LEN & (LEN - 1)) != 0)) begin : g_len_check
        $error("moving_sum: LEN must be a power of two and >= 2");
    end

    logic [SW-1:0] sum_q, sum_n;
    logic [DW-1:0] avg_q, avg_n;
    logic          valid_q, valid_n;
    logic [FW-1:0] fill_q, fill_n;
    logic [SW-1:0] sub;
    logic [SW-1:0] rnd;

    // Next-state: din_dly only leaves the window once the window is full,
    // so stale chain contents after reset/clr are never subtracted.
    always_comb begin
        sum_n   = sum_q;
        avg_n   = avg_q;
        valid_n = valid_q;
        fill_n  = fill_q;
        sub     = '0;
        rnd     = '0;
        if (bus.clr) begin
            sum_n   = '0;
            avg_n   = '0;
            valid_n = 1'b0;
            fill_n  = '0;
        end else if (bus.en) begin
            sub     = (fill_q == FULL) ? SW'(bus.din_dly) : '0;
            sum_n   = sum_q + SW'(bus.din) - sub;
            fill_n  = (fill_q == FULL) ? FULL : fill_q + FW'(1);
            valid_n = (fill_n == FULL);
            rnd     = sum_n + HALF;
            avg_n   = DW'(rnd >> LW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            fill_q  <= '0;
        end else begin
            sum_q   <= sum_n;
            avg_q   <= avg_n;
            valid_q <= valid_n;
            fill_q  <= fill_n;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.avg   = avg_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_moving_sum.sv
// Directed bench for moving_sum with DW=8, LEN=4; expected values are hand-computed.
module tb_moving_sum;
    localparam int unsigned DW  = 8;
    localparam int unsigned LEN = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;

    moving_sum_if #(.DW(DW), .LEN(LEN)) bus ();

    moving_sum #(.DW(DW), .LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs, then sample #1 after the edge that registers them.
    task automatic drive(input logic en, input logic clr, input int din, input int dly);
        bus.en      = en;
        bus.clr     = clr;
        bus.din     = DW'(din);
        bus.din_dly = DW'(dly);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            n_total++;
            if ({bus.sum, bus.avg, bus.valid} !== 19'd0) begin
                $display("FAIL reset[%0d]: got sum=%0d avg=%0d valid=%0b, need 0/0/0",
                         i, bus.sum, bus.avg, bus.valid);
            end else n_pass++;
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 77, 88);
        n_total++;
        if ({bus.sum, bus.avg, bus.valid} !== 19'd0) begin
            $display("FAIL reset_after: got sum=%0d avg=%0d valid=%0b, need 0/0/0",
                     bus.sum, bus.avg, bus.valid);
        end else n_pass++;
    endtask

    task automatic test_fill();
        int din[4]   = '{10, 20, 30, 40};
        int e_sum[4] = '{10, 30, 60, 100};
        int e_avg[4] = '{3, 8, 15, 25};
        int e_val[4] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, din[i], 8'hAA);
            n_total++;
            if (bus.sum !== 10'(e_sum[i]) || bus.avg !== 8'(e_avg[i]) || bus.valid !== 1'(e_val[i])) begin
                $display("FAIL fill[%0d]: got sum=%0d avg=%0d valid=%0b, need %0d/%0d/%0d",
                         i, bus.sum, bus.avg, bus.valid, e_sum[i], e_avg[i], e_val[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_enable_gaps();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            n_total++;
            if (bus.sum !== 10'd100 || bus.avg !== 8'd25 || bus.valid !== 1'b1) begin
                $display("FAIL gap[%0d]: got sum=%0d avg=%0d valid=%0b, need 100/25/1",
                         i, bus.sum, bus.avg, bus.valid);
            end else n_pass++;
        end
        drive(1'b1, 1'b0, 50, 10);
        n_total++;
        if (bus.sum !== 10'd140 || bus.avg !== 8'd35 || bus.valid !== 1'b1) begin
            $display("FAIL gap_resume: got sum=%0d avg=%0d valid=%0b, need 140/35/1",
                     bus.sum, bus.avg, bus.valid);
        end else n_pass++;
    endtask

    task automatic test_steady();
        drive(1'b1, 1'b0, 60, 20);
        n_total++;
        if (bus.sum !== 10'd180 || bus.avg !== 8'd45 || bus.valid !== 1'b1) begin
            $display("FAIL steady: got sum=%0d avg=%0d valid=%0b, need 180/45/1",
                     bus.sum, bus.avg, bus.valid);
        end else n_pass++;
    endtask

    task automatic test_clear();
        int din[5]   = '{1, 2, 3, 4, 5};
        int dly[5]   = '{20, 30, 40, 50, 1};
        int e_sum[5] = '{1, 3, 6, 10, 14};
        int e_avg[5] = '{0, 1, 2, 3, 4};
        int e_val[5] = '{0, 0, 0, 1, 1};
        drive(1'b1, 1'b1, 99, 30);
        n_total++;
        if ({bus.sum, bus.avg, bus.valid} !== 19'd0) begin
            $display("FAIL clear: got sum=%0d avg=%0d valid=%0b, need 0/0/0",
                     bus.sum, bus.avg, bus.valid);
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, din[i], dly[i]);
            n_total++;
            if (bus.sum !== 10'(e_sum[i]) || bus.avg !== 8'(e_avg[i]) || bus.valid !== 1'(e_val[i])) begin
                $display("FAIL refill[%0d]: got sum=%0d avg=%0d valid=%0b, need %0d/%0d/%0d",
                         i, bus.sum, bus.avg, bus.valid, e_sum[i], e_avg[i], e_val[i]);
            end else n_pass++;
        end
    endtask

    // Window {2,3,4,5} -> {1,1,2,2} (sum 6, avg 2) -> {2,1,1,1} (sum 5, avg 1).
    task automatic test_rounding();
        int din[7]   = '{1, 1, 2, 2, 1, 1, 1};
        int dly[7]   = '{2, 3, 4, 5, 1, 1, 2};
        int e_sum[7] = '{13, 11, 9, 6, 6, 6, 5};
        int e_avg[7] = '{3, 3, 2, 2, 2, 2, 1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, din[i], dly[i]);
            n_total++;
            if (bus.sum !== 10'(e_sum[i]) || bus.avg !== 8'(e_avg[i]) || bus.valid !== 1'b1) begin
                $display("FAIL round[%0d]: got sum=%0d avg=%0d valid=%0b, need %0d/%0d/1",
                         i, bus.sum, bus.avg, bus.valid, e_sum[i], e_avg[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_full_scale();
        int din[10]   = '{255, 255, 255, 255, 255, 255, 0, 0, 0, 0};
        int dly[10]   = '{7, 9, 11, 13, 255, 255, 255, 255, 255, 255};
        int e_sum[10] = '{255, 510, 765, 1020, 1020, 1020, 765, 510, 255, 0};
        int e_avg[10] = '{64, 128, 191, 255, 255, 255, 191, 128, 64, 0};
        int e_val[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        drive(1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, din[i], dly[i]);
            n_total++;
            if (bus.sum !== 10'(e_sum[i]) || bus.avg !== 8'(e_avg[i]) || bus.valid !== 1'(e_val[i])) begin
                $display("FAIL full[%0d]: got sum=%0d avg=%0d valid=%0b, need %0d/%0d/%0d",
                         i, bus.sum, bus.avg, bus.valid, e_sum[i], e_avg[i], e_val[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 200, 0);
        n_total++;
        if (bus.sum !== 10'd200 || bus.avg !== 8'd50) begin
            $display("FAIL pre_rst: got sum=%0d avg=%0d, need 200/50", bus.sum, bus.avg);
        end else n_pass++;
        rst = 1'b1;
        drive(1'b1, 1'b1, 123, 45);
        rst = 1'b0;
        n_total++;
        if ({bus.sum, bus.avg, bus.valid} !== 19'd0) begin
            $display("FAIL rst_mid: got sum=%0d avg=%0d valid=%0b, need 0/0/0",
                     bus.sum, bus.avg, bus.valid);
        end else n_pass++;
        drive(1'b1, 1'b0, 8, 99);
        n_total++;
        if (bus.sum !== 10'd8 || bus.avg !== 8'd2 || bus.valid !== 1'b0) begin
            $display("FAIL rst_refill: got sum=%0d avg=%0d valid=%0b, need 8/2/0",
                     bus.sum, bus.avg, bus.valid);
        end else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        bus.din     = '0;
        bus.din_dly = '0;
        #1;
        test_reset();
        test_fill();
        test_enable_gaps();
        test_steady();
        test_clear();
        test_rounding();
        test_full_scale();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
